// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame receiver: state encoding, default
// word width and the serial line levels.
package serial_pkg;

    localparam int unsigned DATA_W_DEF = 8;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_DATA   = 2'd1;
    localparam state_t ST_PARITY = 2'd2;
    localparam state_t ST_STOP   = 2'd3;

endpackage

// File: rtl/rx_shift_reg.sv
// LSB-first receive shift register: each enabled sample enters at the MSB so
// the first bit received ends up in bit 0 after DATA_W shifts.
module rx_shift_reg #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              din,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= {din, q[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// Strobe-gated serial frame receiver: start bit, DATA_W data bits LSB-first,
// optional even parity, stop bit; valid/ready output with sticky error flags.
module serial_frame_rx
    import serial_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sin,
    input  logic              sin_en,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    input  logic              err_clr,
    output logic              busy
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              perr_q;
    logic              shift_en;
    logic              frame_done;
    logic              frame_bad;
    logic              handshake;

    assign shift_en   = sin_en && (state == ST_DATA);
    assign frame_done = sin_en && (state == ST_STOP) && (sin == LINE_STOP);
    assign frame_bad  = sin_en && (state == ST_STOP) && (sin != LINE_STOP);
    assign handshake  = data_valid && data_ready;
    assign busy       = (state != ST_IDLE);

    rx_shift_reg #(
        .DATA_W (DATA_W)
    ) u_shift (
        .clk (clk),
        .rst (rst),
        .en  (shift_en),
        .din (sin),
        .q   (shreg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            perr_q     <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (sin_en) begin
                case (state)
                    ST_IDLE: begin
                        if (sin == LINE_START) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                            perr_q  <= 1'b0;
                        end
                    end
                    ST_DATA: begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    ST_PARITY: begin
                        // shreg already holds the full word here; sin is the parity bit
                        perr_q <= (^shreg) ^ sin;
                        state  <= ST_STOP;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end

            // A completing frame may reuse the slot freed by a same-cycle handshake
            if (frame_done && (!data_valid || data_ready)) begin
                data_out   <= shreg;
                parity_err <= perr_q;
                data_valid <= 1'b1;
            end else if (handshake) begin
                data_valid <= 1'b0;
                parity_err <= 1'b0;
            end

            if (frame_done && data_valid && !data_ready) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end

            if (frame_bad) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: a table of frames with hand-computed
// expectations, plus hand-written reset, sparse-strobe and err_clr sequences.
module tb_serial_frame_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       sin;
    logic       sin_en;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       err_clr;
    logic       busy;

    int n_vec  = 0;
    int n_fail = 0;

    serial_frame_rx #(
        .DATA_W    (8),
        .PARITY_EN (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_en     (sin_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .err_clr    (err_clr),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       pbit;
        logic       stop;
        logic       rdy_stop;
        logic       consume;
        logic       clr_after;
        logic [7:0] exp_dout;
        logic       exp_valid;
        logic       exp_perr;
        logic       exp_ferr;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle: inputs change #1 after a rising edge, stable for the next one
    task automatic step(input logic b, input logic en);
        sin    = b;
        sin_en = en;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input logic rdy);
        step(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(d[i], 1'b1);
        step(p, 1'b1);
        data_ready = rdy;
        step(s, 1'b1);
        data_ready = 1'b0;
        sin        = 1'b1;
        sin_en     = 1'b0;
    endtask

    initial begin
        //          data   p     stop  rdy   cons  clr   dout   val   perr  ferr  ovr
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'h33, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1};

        rst = 1'b1; sin = 1'b1; sin_en = 1'b0; data_ready = 1'b0; err_clr = 1'b0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("reset_busy",  16'(busy), 16'h0);
        chk("reset_valid", 16'(data_valid), 16'h0);
        chk("reset_dout",  16'(data_out), 16'h00);
        chk("reset_ferr",  16'(frame_err), 16'h0);
        chk("reset_ovr",   16'(overrun), 16'h0);
        rst = 1'b0;
        step(1'b1, 1'b1);
        chk("idle_high_busy", 16'(busy), 16'h0);

        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].data, vecs[v].pbit, vecs[v].stop, vecs[v].rdy_stop);
            chk($sformatf("v%0d_dout", v),  16'(data_out),   16'(vecs[v].exp_dout));
            chk($sformatf("v%0d_valid", v), 16'(data_valid), 16'(vecs[v].exp_valid));
            if (vecs[v].exp_valid) chk($sformatf("v%0d_perr", v), 16'(parity_err), 16'(vecs[v].exp_perr));
            chk($sformatf("v%0d_ferr", v),  16'(frame_err),  16'(vecs[v].exp_ferr));
            chk($sformatf("v%0d_ovr", v),   16'(overrun),    16'(vecs[v].exp_ovr));
            chk($sformatf("v%0d_busy", v),  16'(busy),       16'h0);
            if (vecs[v].consume) begin
                data_ready = 1'b1;
                step(1'b1, 1'b0);
                data_ready = 1'b0;
                chk($sformatf("v%0d_consumed", v), 16'(data_valid), 16'h0);
            end
            if (vecs[v].clr_after) begin
                err_clr = 1'b1;
                step(1'b1, 1'b0);
                err_clr = 1'b0;
                chk($sformatf("v%0d_clr_ferr", v), 16'(frame_err), 16'h0);
                chk($sformatf("v%0d_clr_ovr", v),  16'(overrun),   16'h0);
            end
        end

        // Reset mid-frame after the 4th data bit of 0xFF
        step(1'b0, 1'b1);
        chk("mid_busy_after_start", 16'(busy), 16'h1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
        rst = 1'b1;
        step(1'b1, 1'b1);
        rst = 1'b0;
        chk("mid_rst_busy",  16'(busy), 16'h0);
        chk("mid_rst_valid", 16'(data_valid), 16'h0);
        chk("mid_rst_dout",  16'(data_out), 16'h00);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        chk("post_rst_dout",  16'(data_out), 16'h5A);
        chk("post_rst_valid", 16'(data_valid), 16'h1);
        chk("post_rst_perr",  16'(parity_err), 16'h0);
        data_ready = 1'b1;
        step(1'b1, 1'b0);
        data_ready = 1'b0;

        // Sparse strobe: sin flips to the wrong level between strobes
        begin
            logic [10:0] bits;
            bits = {1'b1, 1'b0, 8'hC3, 1'b0};
            for (int i = 0; i < 11; i++) begin
                step(bits[i], 1'b1);
                for (int k = 0; k < 3; k++) step(~bits[i], 1'b0);
                if (i == 5) chk("sparse_busy", 16'(busy), 16'h1);
            end
        end
        chk("sparse_dout",  16'(data_out), 16'hC3);
        chk("sparse_valid", 16'(data_valid), 16'h1);
        chk("sparse_perr",  16'(parity_err), 16'h0);
        chk("sparse_ferr",  16'(frame_err), 16'h0);

        // Stable output while valid and no handshake
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("hold_dout",  16'(data_out), 16'hC3);
        chk("hold_valid", 16'(data_valid), 16'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving data bits per frame (range 4..16).
REQ-002 The block SHALL have parameter PARITY_EN, default 1, where 1 means an even-parity bit follows the data and 0 means no parity bit.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 sin  input  1  serial line; idle high.
REQ-006 sin_en  input  1  bit strobe; sin is sampled only in cycles where sin_en=1.
REQ-007 data_out  output  DATA_W  last received data word, LSB = first received data bit.
REQ-008 data_valid  output  1  data_out holds an unconsumed word.
REQ-009 data_ready  input  1  consumer accepts data_out in a cycle with data_valid=1 and data_ready=1.
REQ-010 parity_err  output  1  parity of the word in data_out mismatched; valid only while data_valid=1.
REQ-011 frame_err  output  1  sticky: a stop bit was sampled as 0.
REQ-012 overrun  output  1  sticky: a completed frame was dropped because data_valid was still 1.
REQ-013 err_clr  input  1  clears frame_err and overrun.
REQ-014 busy  output  1  FSM is not in IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, DATA, PARITY and STOP, and SHALL act only on cycles with sin_en=1, holding all state otherwise.
REQ-016 In IDLE, sampling sin=0 SHALL be the start bit: the FSM moves to DATA and the bit counter is cleared; sampling sin=1 SHALL keep the FSM in IDLE.
REQ-017 In DATA, each sample SHALL shift into the receive register LSB-first; after DATA_W samples the FSM SHALL move to PARITY if PARITY_EN=1, else to STOP.
REQ-018 In PARITY, the sample SHALL be stored and compared against the even parity of the data (XOR of data bits XOR parity bit must be 0), then the FSM SHALL move to STOP.
REQ-019 In STOP, sample=1 SHALL complete the frame; sample=0 SHALL set frame_err and discard the frame; in both cases the FSM SHALL return to IDLE.
REQ-020 On completion, data_out, parity_err and data_valid=1 SHALL be registered on the edge that samples the stop bit, so they are visible the next cycle (1-cycle latency from the stop sample).
REQ-021 A handshake (data_valid=1 and data_ready=1) SHALL clear data_valid on the next edge unless a frame completes in that same cycle.
REQ-022 If a frame completes in the same cycle as a handshake, the new word SHALL load, data_valid SHALL stay 1, and overrun SHALL NOT be set.
REQ-023 If a frame completes while data_valid=1 and data_ready=0, data_out SHALL be unchanged, the new word SHALL be dropped, and overrun SHALL be set.
REQ-024 err_clr SHALL clear frame_err and overrun on the next edge; a set event in the same cycle SHALL take priority (the flag stays 1).
REQ-025 data_out SHALL remain stable while data_valid=1 and no handshake occurs.
REQ-026 sin_en=1 back-to-back for every cycle SHALL be supported; a new start bit SHALL be accepted on the sample immediately after a stop bit.

Reset
REQ-027 rst=1 SHALL force state IDLE, bit counter 0, receive register 0, data_out 0, data_valid 0, parity_err 0, frame_err 0, overrun 0 and busy 0 on the next edge, including mid-frame.
REQ-028 rst SHALL take priority over sin_en, err_clr and data_ready.

Structure
REQ-029 The state encoding typedef, the DATA_W default and the idle/start/stop line-level constants SHALL live in the shared package serial_pkg.
REQ-030 The DATA_W-bit, LSB-first, enable-gated receive shift register SHALL be a sub-module named rx_shift_reg; FSM, counter, parity and handshake logic SHALL stay in serial_frame_rx.

Verification
REQ-031 The bench SHALL drive a nominal frame with sin_en every cycle, PARITY_EN=1: start 0, data 0xA5 LSB-first, parity 0, stop 1 -> data_out=0xA5, data_valid=1 on the cycle after the stop sample, parity_err=0.
REQ-032 The bench SHALL drive a parity error: 0x01 with parity bit 0 -> data_valid=1, parity_err=1.
REQ-033 The bench SHALL drive a framing error: 0x3C with stop bit 0 -> data_valid stays 0, frame_err=1; then err_clr=1 -> frame_err=0 the next cycle.
REQ-034 The bench SHALL test overrun: receive 0x11 with data_ready=0, then receive 0x22 -> data_out stays 0x11 and overrun=1; receive 0x33 while asserting data_ready in the stop-sample cycle -> data_out=0x33, data_valid=1, no further overrun set.
REQ-035 The bench SHALL test reset mid-frame: rst=1 after the 4th data bit of 0xFF -> busy=0 and data_valid=0; a following clean 0x5A frame is received correctly.
REQ-036 The bench SHALL test a sparse strobe: sin_en=1 every 4th cycle with sin toggled between strobes, frame 0xC3 -> data_out=0xC3, showing that samples are taken only on strobe cycles.
